// File: rtl/usb_reg_bridge_pkg.sv
// rtl/usb_reg_bridge_pkg.sv - opcodes, FSM encoding and state helpers for the USB register bridge
package usb_reg_bridge_pkg;

    localparam logic [7:0] USB_OP_WRITE = 8'h00;
    localparam logic [7:0] USB_OP_READ  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RREQ  = 3'd4,
        ST_RCAP  = 3'd5,
        ST_RSEND = 3'd6
    } state_t;

    // States that accept an inbound byte.
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_LEN) || (s == ST_WDATA);
    endfunction

    // Mid-frame states guarded by the inactivity timeout.
    function automatic logic is_timed_state(input state_t s);
        return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_WDATA);
    endfunction

endpackage

// File: rtl/usb_rx_timeout.sv
// rtl/usb_rx_timeout.sv - load-clear inactivity counter for mid-frame rx stalls
module usb_rx_timeout #(
    parameter int pTIMEOUT = 1000000
) (
    input  logic clk_usb,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(pTIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(pTIMEOUT);

    logic [CNT_W-1:0] count;

    assign expired = (count == LIMIT);

    // Count idle cycles while running; any accepted byte or leaving the timed states restarts from zero.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_reg_bridge.sv
// rtl/usb_reg_bridge.sv - USB byte stream to register-bank strobe bridge with read-return stream
module usb_reg_bridge #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pTIMEOUT      = 1000000
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datai,
    output logic                     reg_write,
    output logic                     reg_read,
    input  logic [7:0]               reg_datao,
    output logic                     busy,
    output logic                     err_opcode,
    output logic                     err_timeout,
    input  logic                     err_clear
);
    import usb_reg_bridge_pkg::*;

    state_t     state, state_next;
    logic       is_read;
    logic [7:0] burst_len;
    logic [7:0] byte_idx;
    logic [7:0] idx_inc;
    logic       ready_en;
    logic       rx_fire;
    logic       tx_fire;
    logic       opcode_ok;
    logic       last_byte;
    logic       expired;
    logic       set_opcode_err;
    logic       set_timeout_err;

    // rx_ready is held low through reset and the first edge after release.
    assign rx_ready        = ready_en & is_rx_state(state);
    assign rx_fire         = rx_valid & rx_ready;
    assign tx_fire         = tx_valid & tx_ready;
    assign busy            = (state != ST_IDLE);
    assign opcode_ok       = (rx_data == USB_OP_WRITE) || (rx_data == USB_OP_READ);
    assign idx_inc         = byte_idx + 8'd1;
    assign last_byte       = (idx_inc == burst_len);
    assign set_opcode_err  = (state == ST_IDLE) && rx_fire && !opcode_ok;
    assign set_timeout_err = is_timed_state(state) && expired && !rx_fire;

    usb_rx_timeout #(
        .pTIMEOUT(pTIMEOUT)
    ) u_rx_timeout (
        .clk_usb (clk_usb),
        .reset_n (reset_n),
        .clear   (rx_fire),
        .run     (is_timed_state(state)),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; an accepted byte takes priority over a coincident timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (rx_fire && opcode_ok) state_next = ST_ADDR;
            ST_ADDR:  begin
                if (rx_fire)      state_next = ST_LEN;
                else if (expired) state_next = ST_IDLE;
            end
            ST_LEN:   begin
                if (rx_fire) begin
                    if (rx_data == 8'd0) state_next = ST_IDLE;
                    else if (is_read)    state_next = ST_RREQ;
                    else                 state_next = ST_WDATA;
                end else if (expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (rx_fire) begin
                    if (last_byte) state_next = ST_IDLE;
                end else if (expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RREQ:  state_next = ST_RCAP;
            ST_RCAP:  state_next = ST_RSEND;
            ST_RSEND: if (tx_fire) state_next = last_byte ? ST_IDLE : ST_RREQ;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered register-bank strobes, burst bookkeeping and read-return byte.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            ready_en    <= 1'b0;
            is_read     <= 1'b0;
            burst_len   <= 8'd0;
            byte_idx    <= 8'd0;
            reg_address <= 8'd0;
            reg_bytecnt <= '0;
            reg_datai   <= 8'd0;
            reg_write   <= 1'b0;
            reg_read    <= 1'b0;
            tx_data     <= 8'd0;
            tx_valid    <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            reg_write <= 1'b0;
            reg_read  <= (state_next == ST_RREQ);
            case (state)
                ST_IDLE:  if (rx_fire && opcode_ok) is_read <= (rx_data == USB_OP_READ);
                ST_ADDR:  if (rx_fire) reg_address <= rx_data;
                ST_LEN:   begin
                    if (rx_fire) begin
                        burst_len   <= rx_data;
                        byte_idx    <= 8'd0;
                        reg_bytecnt <= '0;
                    end
                end
                ST_WDATA: begin
                    if (rx_fire) begin
                        reg_write   <= 1'b1;
                        reg_datai   <= rx_data;
                        reg_bytecnt <= byte_idx[pBYTECNT_SIZE-1:0];
                        byte_idx    <= idx_inc;
                    end
                end
                ST_RCAP:  begin
                    tx_data  <= reg_datao;
                    tx_valid <= 1'b1;
                end
                ST_RSEND: begin
                    if (tx_fire) begin
                        tx_valid    <= 1'b0;
                        byte_idx    <= idx_inc;
                        reg_bytecnt <= idx_inc[pBYTECNT_SIZE-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (set_opcode_err)  err_opcode <= 1'b1;
            else if (err_clear)  err_opcode <= 1'b0;
            if (set_timeout_err) err_timeout <= 1'b1;
            else if (err_clear)  err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_reg_bridge.sv
// tb/tb_usb_reg_bridge.sv - self-checking bench for usb_reg_bridge
module tb_usb_reg_bridge;

    localparam int BC = 7;
    localparam int TO = 16;

    logic          clk_usb = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [7:0]    reg_address;
    logic [BC-1:0] reg_bytecnt;
    logic [7:0]    reg_datai;
    logic          reg_write;
    logic          reg_read;
    logic [7:0]    reg_datao = 8'd0;
    logic          busy;
    logic          err_opcode;
    logic          err_timeout;
    logic          err_clear = 1'b0;

    usb_reg_bridge #(
        .pBYTECNT_SIZE(BC),
        .pTIMEOUT     (TO)
    ) dut (
        .clk_usb     (clk_usb),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .reg_address (reg_address),
        .reg_bytecnt (reg_bytecnt),
        .reg_datai   (reg_datai),
        .reg_write   (reg_write),
        .reg_read    (reg_read),
        .reg_datao   (reg_datao),
        .busy        (busy),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout),
        .err_clear   (err_clear)
    );

    always #5 clk_usb = ~clk_usb;

    int errors = 0;
    int checks = 0;

    logic [22:0] exp_wr_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  rd_q[$];
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_tx = 0;
    int          wr_run = 0;
    logic        prev_wr = 1'b0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] addr;
        logic [7:0] len;
        logic [7:0] d[4];
        int         exp_wr;
        int         exp_rd;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] len,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                input logic [7:0] d3, input int wr, input int rd);
        vec_t v;
        v.op = op; v.addr = addr; v.len = len;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.exp_wr = wr; v.exp_rd = rd;
        return v;
    endfunction

    // Register-bank read model: data appears the cycle after reg_read, filler otherwise.
    always @(posedge clk_usb) begin
        if (reg_read) reg_datao <= (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
        else          reg_datao <= 8'hC3;
    end

    // Scoreboard monitor, sampled mid-cycle once inputs for the next edge are settled.
    always @(negedge clk_usb) begin
        #1;
        if (reset_n) begin
            if (reg_write) begin
                n_wr++;
                wr_run = prev_wr ? wr_run + 1 : 1;
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got %0h expected none", {reg_address, reg_bytecnt, reg_datai});
                end else begin
                    check("write_addr_cnt_data", {reg_address, reg_bytecnt, reg_datai}, exp_wr_q.pop_front());
                end
            end
            prev_wr = reg_write;
            if (reg_read) n_rd++;
            if (tx_valid && tx_ready) begin
                n_tx++;
                if (exp_tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx: got %0h expected none", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_tx_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk_usb);
            n++;
        end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: rx_ready got 0 expected 1");
        end
        @(negedge clk_usb);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk_usb);
            n++;
        end
        check(name, busy, 1'b0);
        tick(3);
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk_usb);
            n++;
        end
        check("tx_valid_arrives", tx_valid, 1'b1);
    endtask

    int   w0, r0, t0;
    logic ok;

    initial begin
        tbl[0] = mk(8'h00, 8'h05, 8'd3, 8'hAA, 8'hBB, 8'hCC, 8'h00, 3, 0);
        tbl[1] = mk(8'h80, 8'h10, 8'd2, 8'h12, 8'h34, 8'h00, 8'h00, 0, 2);
        tbl[2] = mk(8'h00, 8'hFF, 8'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 1, 0);
        tbl[3] = mk(8'h80, 8'h00, 8'd4, 8'h01, 8'h02, 8'h03, 8'h04, 0, 4);
        tbl[4] = mk(8'h00, 8'h07, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        tbl[5] = mk(8'h80, 8'h08, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

        // Reset state and rx_ready release timing.
        #2;
        check("reset_outputs", {rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt, reg_datai,
                                reg_write, reg_read, busy, err_opcode, err_timeout}, 0);
        tick(3);
        reset_n = 1'b1;
        #1;
        check("rx_ready_before_edge", rx_ready, 1'b0);
        @(negedge clk_usb);
        check("rx_ready_after_release", rx_ready, 1'b1);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            w0 = n_wr; r0 = n_rd; t0 = n_tx;
            for (int i = 0; i < int'(tbl[v].len); i++) begin
                if (tbl[v].op == 8'h00) begin
                    exp_wr_q.push_back({tbl[v].addr, 7'(i), tbl[v].d[i]});
                end else begin
                    rd_q.push_back(tbl[v].d[i]);
                    exp_tx_q.push_back(tbl[v].d[i]);
                end
            end
            send_byte(tbl[v].op);
            send_byte(tbl[v].addr);
            send_byte(tbl[v].len);
            if (tbl[v].op == 8'h00)
                for (int i = 0; i < int'(tbl[v].len); i++) send_byte(tbl[v].d[i]);
            wait_idle($sformatf("vec%0d_idle", v));
            check($sformatf("vec%0d_writes", v), n_wr - w0, tbl[v].exp_wr);
            check($sformatf("vec%0d_reads", v), n_rd - r0, tbl[v].exp_rd);
            check($sformatf("vec%0d_tx", v), n_tx - t0, tbl[v].exp_rd);
            check($sformatf("vec%0d_err", v), {err_opcode, err_timeout}, 2'b00);
            if (tbl[v].exp_wr > 1) check($sformatf("vec%0d_back_to_back", v), wr_run, tbl[v].exp_wr);
        end

        // Long write burst: bytecnt wraps modulo 128.
        w0 = n_wr;
        for (int i = 0; i < 130; i++) exp_wr_q.push_back({8'h40, 7'(i % 128), 8'(i)});
        send_byte(8'h00); send_byte(8'h40); send_byte(8'd130);
        for (int i = 0; i < 130; i++) send_byte(8'(i));
        wait_idle("wrap_idle");
        check("wrap_writes", n_wr - w0, 130);
        check("wrap_back_to_back", wr_run, 130);

        // Read with tx_ready stalled for 10 cycles.
        r0 = n_rd; t0 = n_tx;
        rd_q.push_back(8'h5A); rd_q.push_back(8'h6B);
        exp_tx_q.push_back(8'h5A); exp_tx_q.push_back(8'h6B);
        tx_ready = 1'b0;
        send_byte(8'h80); send_byte(8'h30); send_byte(8'd2);
        wait_tx_valid();
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_usb);
            if (!tx_valid || tx_data != 8'h5A || reg_read) ok = 1'b0;
        end
        check("stall_hold", ok, 1'b1);
        check("stall_single_read", n_rd - r0, 1);
        check("stall_address", reg_address, 8'h30);
        tx_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_reads", n_rd - r0, 2);
        check("stall_tx", n_tx - t0, 2);

        // Illegal opcode then a valid write; clear; error beats a concurrent clear.
        w0 = n_wr;
        send_byte(8'h42);
        check("opcode_err_set", err_opcode, 1'b1);
        check("opcode_busy", busy, 1'b0);
        exp_wr_q.push_back({8'h01, 7'd0, 8'h77});
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h77);
        wait_idle("opcode_idle");
        check("opcode_write", n_wr - w0, 1);
        check("opcode_sticky", err_opcode, 1'b1);
        err_clear = 1'b1;
        @(negedge clk_usb);
        err_clear = 1'b0;
        check("opcode_cleared", err_opcode, 1'b0);
        err_clear = 1'b1;
        send_byte(8'h55);
        err_clear = 1'b0;
        check("opcode_err_wins", err_opcode, 1'b1);
        err_clear = 1'b1;
        @(negedge clk_usb);
        err_clear = 1'b0;

        // Stalled header times out; zero-length frame issues nothing.
        w0 = n_wr;
        send_byte(8'h00); send_byte(8'h05);
        tick(8);
        check("timeout_not_yet", err_timeout, 1'b0);
        check("timeout_busy_mid", busy, 1'b1);
        for (int i = 0; i < 40 && !err_timeout; i++) @(negedge clk_usb);
        check("timeout_set", err_timeout, 1'b1);
        check("timeout_idle", busy, 1'b0);
        check("timeout_no_write", n_wr - w0, 0);
        err_clear = 1'b1;
        @(negedge clk_usb);
        err_clear = 1'b0;
        check("timeout_cleared", err_timeout, 1'b0);

        // Reset mid-read while tx_valid is high.
        rd_q.push_back(8'h99); rd_q.push_back(8'h98); rd_q.push_back(8'h97);
        tx_ready = 1'b0;
        send_byte(8'h80); send_byte(8'h20); send_byte(8'd3);
        wait_tx_valid();
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt, reg_datai,
                                   reg_write, reg_read, busy, err_opcode, err_timeout}, 0);
        @(negedge clk_usb);
        reset_n = 1'b1;
        rd_q.delete();
        w0 = n_wr; r0 = n_rd; t0 = n_tx;
        tx_ready = 1'b1;
        tick(10);
        check("midreset_no_read", n_rd - r0, 0);
        check("midreset_no_write", n_wr - w0, 0);
        check("midreset_no_tx", n_tx - t0, 0);
        check("midreset_idle", busy, 1'b0);

        check("drain_writes", exp_wr_q.size(), 0);
        check("drain_tx", exp_tx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_reg_bridge.md
# usb_reg_bridge

Upstream front end of the register bank: converts the byte stream from the USB endpoint into the register-access strobes (`reg_address`, `reg_bytecnt`, `reg_datai`, `reg_write`, `reg_read`) and returns read data (`reg_datao`) as an outbound byte stream. It decodes a 3-byte header, runs multi-byte write and read bursts with per-byte `reg_bytecnt` sequencing, and aborts stalled frames on timeout.

## Interface
- `pBYTECNT_SIZE`, 7: width of `reg_bytecnt`; must match the register bank.
- `pTIMEOUT`, 1000000: clk_usb cycles of rx inactivity mid-frame before abort.
- `clk_usb`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  inbound byte.
- `rx_valid`  in  1  inbound byte valid.
- `rx_ready`  out  1  block accepts `rx_data`.
- `tx_data`  out  8  read-return byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts `tx_data`.
- `reg_address`  out  8  register address.
- `reg_bytecnt`  out  pBYTECNT_SIZE  byte index within burst.
- `reg_datai`  out  8  write data.
- `reg_write`  out  1  one-cycle write strobe.
- `reg_read`  out  1  one-cycle read strobe.
- `reg_datao`  in  8  read data, valid exactly one cycle after `reg_read`.
- `busy`  out  1  high whenever state is not IDLE.
- `err_opcode`  out  1  sticky: illegal opcode seen.
- `err_timeout`  out  1  sticky: frame aborted by timeout.
- `err_clear`  in  1  clears both sticky flags.

## Operation
- Frame: byte0 opcode (0x00 write, 0x80 read), byte1 address, byte2 length N (1..255); write frames follow with N data bytes.
- States: IDLE, ADDR, LEN, WDATA, RREQ, RCAP, RSEND.
- IDLE/ADDR/LEN/WDATA: `rx_ready`=1; a byte is consumed on `rx_valid & rx_ready`.
- IDLE: 0x00/0x80 -> ADDR; any other value -> set `err_opcode`, stay IDLE (byte dropped; next byte is a new opcode).
- ADDR: latch `reg_address` -> LEN. LEN: N=0 -> IDLE, no access; else latch N, clear byte counter, -> WDATA (write) or RREQ (read).
- WDATA: per accepted byte, next cycle `reg_write`=1 with `reg_datai`=byte and `reg_bytecnt`=current index; index then increments. After N-th byte -> IDLE.
- RREQ: `rx_ready`=0; `reg_read`=1 for one cycle -> RCAP. RCAP: capture `reg_datao` into `tx_data`, assert `tx_valid` -> RSEND. RSEND: hold until `tx_ready`; on handshake drop `tx_valid`, increment index; -> RREQ if bytes remain, else IDLE.
- Byte index is 8 bits; `reg_bytecnt` is its low pBYTECNT_SIZE bits (wraps modulo 2^pBYTECNT_SIZE for long bursts).
- Timeout counter runs in ADDR, LEN, WDATA only; cleared on every accepted rx byte and on state entry. Reaching pTIMEOUT -> IDLE, set `err_timeout`; pending write strobe still issues. No timeout in read states.
- `err_clear` concurrent with a new error: error wins (flag stays set).

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0 (`reg_address`, `reg_bytecnt`, `reg_datai`, `tx_data` = 0; strobes, `tx_valid`, `busy`, error flags = 0). `rx_ready` becomes 1 first cycle after release.
- Reset mid-frame: frame discarded, `tx_valid` dropped without handshake, no further strobes.
- All reg_* outputs registered; write latency 1 cycle from rx acceptance; write throughput 1 byte/cycle.
- Read: `reg_read` at cycle t, capture at t+1, `tx_valid` from t+2; minimum 3 cycles/byte with `tx_ready` held high.
- `reg_address`/`reg_bytecnt` stable during every strobe cycle and during the capture cycle.

## Structure
- `includes.v` gains `USB_OP_WRITE` (8'h00), `USB_OP_READ` (8'h80) and the state encodings.
- One sub-module: `usb_rx_timeout` (load-clear counter, `expired` output, width $clog2(pTIMEOUT+1)).

## Test plan
- Frame 00 05 03 AA BB CC -> three `reg_write` pulses, addr 0x05, bytecnt 0/1/2, datai AA/BB/CC on consecutive cycles; IDLE after.
- Frame 80 10 02, model returns 0x12 then 0x34 one cycle after each `reg_read` -> tx bytes 12, 34; exactly two `reg_read` pulses.
- Read N=2 with `tx_ready` low 10 cycles -> `tx_valid`/`tx_data` held, no second `reg_read` until handshake.
- Opcode 0x42 then 00 01 01 77 -> `err_opcode`=1, write of 0x77 to 0x01 still occurs; `err_clear` -> 0.
- 00 05 then silence, pTIMEOUT=16 -> after 16 idle cycles `err_timeout`=1, IDLE, no `reg_write`; length 0 frame -> no strobes.
- `reset_n` low mid-read with `tx_valid`=1 -> all outputs 0 immediately, no strobe after release.
